// File: rtl/fetch_prefetch_buffer_pkg.sv
// Shared fetch front-end constants and the prefetch FSM state type.
package fetch_prefetch_buffer_pkg;

    localparam int unsigned RISCV_ADDR_WIDTH  = 32;
    localparam int unsigned RISCV_WORD_WIDTH  = 32;
    localparam int unsigned RISCV_INSTR_BYTES = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_prefetch_buffer_sync_fifo.sv
// Single-clock FIFO with a registered head word and a synchronous flush.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_pop;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    always_comb begin
        w_pop        = i_pop && (r_count != '0);
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
        w_count_nxt  = r_count + CNT_W'(i_push) - CNT_W'(w_pop);
        // A push into a FIFO that is (or becomes) empty lands directly in the head.
        if (i_push && (r_count == CNT_W'(w_pop)))
            w_head_nxt = i_data;
        else
            w_head_nxt = r_mem[w_rd_ptr_nxt];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_push);
            r_count  <= w_count_nxt;
            r_head   <= w_head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush)
            r_mem[r_wr_ptr] <= i_data;
    end

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_head;

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetcher: credit-limited sequential fetch into a FIFO, with
// redirect flush and discard of stale in-flight ROM responses.
module fetch_prefetch_buffer
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = RISCV_ADDR_WIDTH,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  mem_valid_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ready_i,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  instr_valid_o,
    output logic [31:0]           instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    input  logic                  instr_ready_i
);

    localparam int unsigned           CNT_W      = $clog2(DEPTH) + 1;
    localparam int unsigned           FIFO_W     = RISCV_WORD_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(RISCV_INSTR_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(RISCV_INSTR_BYTES);
    localparam logic [CNT_W:0]        OCC_LIMIT  = (CNT_W + 1)'(DEPTH);

    fetch_state_t          r_state;
    logic                  r_mem_valid;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_req_pc;
    logic [CNT_W-1:0]      r_outstanding;
    logic [CNT_W-1:0]      r_discard;

    logic                  w_resp;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CNT_W-1:0]      w_fifo_count;
    logic [CNT_W:0]        w_occ;
    logic [CNT_W-1:0]      w_outstanding_nxt;
    logic [CNT_W-1:0]      w_discard_nxt;
    logic [ADDR_WIDTH-1:0] w_redirect_pc;
    logic [FIFO_W-1:0]     w_fifo_head;

    always_comb begin
        w_redirect_pc = redirect_pc_i & ALIGN_MASK;
        // A response with nothing outstanding is a leftover from before reset.
        w_resp        = mem_ready_i && (r_outstanding != '0);
        w_pop         = !w_fifo_empty && instr_ready_i && !redirect_i;
        w_push        = w_resp && (r_discard == '0) && !redirect_i && (!w_fifo_full || w_pop);
        w_occ         = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
        w_issue       = !redirect_i &&
                        ((w_occ < OCC_LIMIT) || ((w_occ == OCC_LIMIT) && w_pop));
        if (redirect_i) begin
            w_discard_nxt     = r_outstanding - CNT_W'(w_resp);
            w_outstanding_nxt = w_discard_nxt + CNT_W'(1);
        end else begin
            w_discard_nxt     = r_discard - CNT_W'(w_resp && (r_discard != '0));
            w_outstanding_nxt = r_outstanding - CNT_W'(w_resp) + CNT_W'(w_issue);
        end
    end

    // On redirect the target request is launched at once (on the bus next cycle),
    // so the first new instruction is visible two cycles after that.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_mem_valid   <= 1'b0;
            r_mem_addr    <= RESET_PC & ALIGN_MASK;
            r_fetch_pc    <= RESET_PC & ALIGN_MASK;
            r_req_pc      <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_req_pc      <= r_mem_addr;
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
            if (redirect_i) begin
                r_mem_valid <= 1'b1;
                r_mem_addr  <= w_redirect_pc;
                r_fetch_pc  <= w_redirect_pc + PC_STEP;
                r_state     <= (w_discard_nxt != '0) ? ST_FLUSH : ST_RUN;
            end else begin
                r_mem_valid <= w_issue;
                if (w_issue) begin
                    r_mem_addr <= r_fetch_pc;
                    r_fetch_pc <= r_fetch_pc + PC_STEP;
                end
                if ((r_state == ST_FLUSH) && (w_discard_nxt == '0))
                    r_state <= ST_RUN;
            end
        end
    end

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({mem_rdata_i, r_req_pc}),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count),
        .o_head  (w_fifo_head)
    );

    assign mem_valid_o   = r_mem_valid;
    assign mem_addr_o    = r_mem_addr;
    assign instr_valid_o = !w_fifo_empty;
    assign instr_o       = w_fifo_head[FIFO_W-1 -: 32];
    assign instr_pc_o    = w_fifo_head[ADDR_WIDTH-1:0];

endmodule

// File: doc/fetch_prefetch_buffer.md
Name: fetch_prefetch_buffer

Overview:
- Instruction-fetch front end. It sits directly upstream of the dual-port instruction ROM and drives its A-side request port (valid/addr in, ready/rdata back).
- Generates sequential word addresses and keeps up to DEPTH requests in flight plus buffered.
- Queues returned words with their PC in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles redirects (branch/jump/trap) by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- ADDR_WIDTH, `RISCV_ADDR_WIDTH, width of PC and memory address.
- DEPTH, 4, FIFO entries and the in-flight credit limit; power of two, minimum 2.
- RESET_PC, 0, first fetch address after reset; word aligned.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_valid_o  output  1  request strobe to ROM port A.
- mem_addr_o  output  ADDR_WIDTH  byte address of request; bits [1:0] always 0.
- mem_ready_i  input  1  response strobe; rdata is valid this cycle.
- mem_rdata_i  input  32  instruction word returned.
- redirect_i  input  1  flush and restart fetch.
- redirect_pc_i  input  ADDR_WIDTH  new fetch address; bits [1:0] ignored (forced 0).
- instr_valid_o  output  1  FIFO head valid.
- instr_o  output  32  FIFO head instruction.
- instr_pc_o  output  ADDR_WIDTH  PC of instr_o.
- instr_ready_i  input  1  decode accepts head; pop when valid and ready.

Behaviour:
- Reset (async assert, sync release):
  - mem_valid_o=0, mem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0.
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0.
- Memory protocol:
  - A request is a single cycle with mem_valid_o=1.
  - The ROM answers with mem_ready_i=1 exactly one cycle later, in order.
  - Back-to-back requests are allowed, one per cycle.
  - mem_valid_o and mem_addr_o are registered.
- Credit and issue:
  - Define occupancy = fifo_count + outstanding.
  - Issue in a cycle when redirect_i=0 and either occupancy < DEPTH, or occupancy == DEPTH and a pop occurs this cycle.
  - On issue: mem_addr_o=fetch_pc, fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH), outstanding++.
- Response:
  - On mem_ready_i with discard==0: push {rdata, pc} into the FIFO, outstanding--.
  - On mem_ready_i with discard>0: drop the word, discard--, outstanding--.
  - Push into a full FIFO is impossible by construction; the bench asserts it never happens.
- Output:
  - instr_valid_o, instr_o and instr_pc_o reflect the FIFO head only; there is no bypass.
  - Latency is request cycle N, response N+1, instr_valid_o=1 at N+2.
  - Steady-state throughput is one instruction per cycle with instr_ready_i held at 1.
  - Head data is stable while valid && !ready.
- Redirect (cycle R, redirect_i=1):
  - FIFO is cleared; instr_valid_o=0 at R+1.
  - A pop in cycle R is ignored.
  - discard = outstanding minus any response arriving in R (that response is also dropped).
  - No request is issued in R. fetch_pc=redirect_pc_i & ~3.
  - First new request at R+1; its instruction is visible at R+3.
  - Back-to-back redirects: the last one wins; each recomputes discard.
- Counters: outstanding and discard are $clog2(DEPTH)+1 bits wide. Outstanding never exceeds DEPTH.
- State machine:
  - RUN: normal operation.
  - FLUSH: entered on redirect while discard>0. Issuing continues; the block returns to RUN when discard reaches 0.
  - The FSM state is visible only as a debug signal.
- Reset mid-operation: all state is cleared immediately. A late mem_ready_i after reset release is treated as a normal response only if outstanding>0; otherwise it is ignored.

Decomposition:
- Shared package/defines (riscv_defines.v): `RISCV_ADDR_WIDTH, `RISCV_WORD_WIDTH, `RISCV_INSTR_BYTES (4).
- Sub-module sync_fifo: parameters WIDTH and DEPTH; ports push/pop/flush/full/empty/count, registered head. Instantiated with WIDTH = 32 + ADDR_WIDTH.
- Credit, discard and PC logic stay in the top module.

Test Plan:
- Reset release, ROM model with mem[0..3]=0x11,0x22,0x33,0x44, ready=1 → requests at 0,4,8,C on consecutive cycles; instr 0x11@pc0 appears 2 cycles after the first request; one instruction per cycle after that.
- Backpressure: hold instr_ready_i=0 with DEPTH=4 → exactly 4 requests issued, then mem_valid_o=0; release → pops resume and a new request issues in the same cycle as the first pop.
- Redirect with 1 outstanding to 0x100 → the stale word is dropped, instr_valid_o=0 at R+1, first delivered instr has pc 0x100 at R+3.
- Redirect in the same cycle as a pop and a response → FIFO empty, no extra instruction delivered, discard ends at 0.
- Two redirects in consecutive cycles (0x40 then 0x80) → only pc 0x80 onward is delivered.
- Async reset asserted mid-stream → outputs return to reset values without waiting for a clock edge; the fetch sequence restarts at RESET_PC.
